// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared constants, FSM encoding and dash clipping helper for the lane scroller
package lane_pkg;

    localparam int LANE_PERIOD   = 104;
    localparam int LANE_DASH_LEN = 64;
    localparam int LANE_V_ACTIVE = 480;

    // start > end, so a hidden dash never matches any row in the renderer
    localparam logic [9:0] HIDDEN_START = 10'h3FF;
    localparam logic [9:0] HIDDEN_END   = 10'h000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_CALC   = 2'd2,
        ST_COMMIT = 2'd3
    } lane_state_t;

    typedef struct packed {
        logic [9:0] r_start;
        logic [9:0] r_end;
    } dash_t;

    // raw: signed top row of the dash; dash_m1: dash height - 1; v_max: last visible row
    function automatic dash_t clip_dash(input logic signed [10:0] raw,
                                        input logic signed [10:0] dash_m1,
                                        input logic signed [10:0] v_max);
        logic signed [10:0] rend;
        dash_t              d;
        rend = raw + dash_m1;
        if (rend < 11'sd0 || raw > v_max) begin
            d.r_start = HIDDEN_START;
            d.r_end   = HIDDEN_END;
        end else begin
            d.r_start = (raw < 11'sd0) ? 10'd0 : raw[9:0];
            d.r_end   = (rend > v_max) ? v_max[9:0] : rend[9:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/lane_dash_clip.sv
// rtl/lane_dash_clip.sv - combinational clip of one dash's raw row offset to the visible area
//
// Ports:
//   raw      in  11 signed top row of the dash (may be negative or beyond the screen)
//   r_start  out 10 clipped first row, HIDDEN_START when fully off-screen
//   r_end    out 10 clipped last row, HIDDEN_END when fully off-screen
module lane_dash_clip
    import lane_pkg::*;
#(
    parameter int DASH_LEN = LANE_DASH_LEN,
    parameter int V_ACTIVE = LANE_V_ACTIVE
) (
    input  logic signed [10:0] raw,
    output logic [9:0]         r_start,
    output logic [9:0]         r_end
);

    localparam logic signed [10:0] DASH_M1 = 11'(DASH_LEN - 1);
    localparam logic signed [10:0] V_MAX   = 11'(V_ACTIVE - 1);

    dash_t d;

    assign d       = clip_dash(raw, DASH_M1, V_MAX);
    assign r_start = d.r_start;
    assign r_end   = d.r_end;

endmodule

// File: rtl/lane_scroll_ctrl.sv
// rtl/lane_scroll_ctrl.sv - per-frame scroll, speed ramp and atomic commit of six lane dash row extents
//
// Ports:
//   clk            in  1  pixel clock
//   reset_n        in  1  synchronous active-low reset
//   frame_tick     in  1  one-cycle pulse per frame
//   run            in  1  game running; 0 ramps speed to zero
//   target_speed   in  4  requested rows per frame
//   lineN_r_start  out 10 dash N first row (N = 1..6)
//   lineN_r_end    out 10 dash N last row
//   line_cX_*      out 10 constant column bounds of lane lines 1 and 2
//   cur_speed      out 4  current ramped speed
//   busy           out 1  update in progress
//   update_done    out 1  one-cycle pulse after the outputs change
module lane_scroll_ctrl
    import lane_pkg::*;
#(
    parameter int PERIOD      = LANE_PERIOD,
    parameter int DASH_LEN    = LANE_DASH_LEN,
    parameter int V_ACTIVE    = LANE_V_ACTIVE,
    parameter int RAMP_FRAMES = 8,
    parameter int C1_START    = 212,
    parameter int C1_END      = 215,
    parameter int C2_START    = 424,
    parameter int C2_END      = 427
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic [3:0] target_speed,
    output logic [9:0] line1_r_start,
    output logic [9:0] line1_r_end,
    output logic [9:0] line2_r_start,
    output logic [9:0] line2_r_end,
    output logic [9:0] line3_r_start,
    output logic [9:0] line3_r_end,
    output logic [9:0] line4_r_start,
    output logic [9:0] line4_r_end,
    output logic [9:0] line5_r_start,
    output logic [9:0] line5_r_end,
    output logic [9:0] line6_r_start,
    output logic [9:0] line6_r_end,
    output logic [9:0] line_c1_start,
    output logic [9:0] line_c1_end,
    output logic [9:0] line_c2_start,
    output logic [9:0] line_c2_end,
    output logic [3:0] cur_speed,
    output logic       busy,
    output logic       update_done
);

    localparam int                 RW        = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RW-1:0]      RAMP_LAST = RW'(RAMP_FRAMES - 1);
    localparam logic signed [10:0] PERIOD_S  = 11'(PERIOD);
    localparam logic signed [10:0] DASH_M1   = 11'(DASH_LEN - 1);
    localparam logic signed [10:0] V_MAX     = 11'(V_ACTIVE - 1);

    lane_state_t        state_q, state_d;
    logic [6:0]         offset_q;
    logic [3:0]         speed_q;
    logic [RW-1:0]      ramp_cnt_q;
    logic               pending_q;
    logic [2:0]         idx_q;
    logic signed [10:0] raw_q;
    logic               done_q;
    logic [9:0]         sh_start [0:5];
    logic [9:0]         sh_end   [0:5];
    logic [9:0]         out_start[0:5];
    logic [9:0]         out_end  [0:5];

    logic [7:0]         sum;
    logic [6:0]         next_offset;
    logic [3:0]         goal;
    logic [9:0]         clip_start, clip_end;
    dash_t              rst_pat [0:5];

    // Offset-0 pattern, restored by reset so the renderer always sees a sane frame
    for (genvar g = 0; g < 6; g++) begin : g_rst_pat
        assign rst_pat[g] = clip_dash(11'(g * PERIOD - PERIOD), DASH_M1, V_MAX);
    end

    // Speed never reaches PERIOD, so one conditional subtract keeps the offset in range
    assign sum         = {1'b0, offset_q} + {4'b0, speed_q};
    assign next_offset = (sum >= 8'(PERIOD)) ? 7'(sum - 8'(PERIOD)) : sum[6:0];
    assign goal        = run ? target_speed : 4'd0;

    // raw_q walks from offset - PERIOD upward by PERIOD, one dash per CALC cycle
    lane_dash_clip #(
        .DASH_LEN (DASH_LEN),
        .V_ACTIVE (V_ACTIVE)
    ) u_clip (
        .raw     (raw_q),
        .r_start (clip_start),
        .r_end   (clip_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_tick) state_d = ST_STEP;
            ST_STEP:   state_d = ST_CALC;
            ST_CALC:   if (idx_q == 3'd5) state_d = ST_COMMIT;
            // A tick landing on the commit cycle is served straight away
            ST_COMMIT: state_d = (pending_q || frame_tick) ? ST_STEP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            offset_q   <= 7'd0;
            speed_q    <= 4'd0;
            ramp_cnt_q <= '0;
            pending_q  <= 1'b0;
            idx_q      <= 3'd0;
            raw_q      <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                sh_start[i]  <= rst_pat[i].r_start;
                sh_end[i]    <= rst_pat[i].r_end;
                out_start[i] <= rst_pat[i].r_start;
                out_end[i]   <= rst_pat[i].r_end;
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_COMMIT);

            if (state_q == ST_IDLE || state_q == ST_COMMIT) begin
                pending_q <= 1'b0;
            end else if (frame_tick) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_STEP: begin
                    offset_q <= next_offset;
                    raw_q    <= $signed({4'b0, next_offset}) - PERIOD_S;
                    idx_q    <= 3'd0;
                    if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_q <= '0;
                        if (speed_q < goal) begin
                            speed_q <= speed_q + 4'd1;
                        end else if (speed_q > goal) begin
                            speed_q <= speed_q - 4'd1;
                        end
                    end else begin
                        ramp_cnt_q <= ramp_cnt_q + 1'b1;
                    end
                end
                ST_CALC: begin
                    sh_start[idx_q] <= clip_start;
                    sh_end[idx_q]   <= clip_end;
                    raw_q           <= raw_q + PERIOD_S;
                    idx_q           <= idx_q + 3'd1;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 6; i++) begin
                        out_start[i] <= sh_start[i];
                        out_end[i]   <= sh_end[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign line1_r_start = out_start[0];
    assign line1_r_end   = out_end[0];
    assign line2_r_start = out_start[1];
    assign line2_r_end   = out_end[1];
    assign line3_r_start = out_start[2];
    assign line3_r_end   = out_end[2];
    assign line4_r_start = out_start[3];
    assign line4_r_end   = out_end[3];
    assign line5_r_start = out_start[4];
    assign line5_r_end   = out_end[4];
    assign line6_r_start = out_start[5];
    assign line6_r_end   = out_end[5];

    assign line_c1_start = 10'(C1_START);
    assign line_c1_end   = 10'(C1_END);
    assign line_c2_start = 10'(C2_START);
    assign line_c2_end   = 10'(C2_END);

    assign cur_speed   = speed_q;
    assign busy        = (state_q != ST_IDLE);
    assign update_done = done_q;

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// tb/tb_lane_scroll_ctrl.sv - scoreboard bench for lane_scroll_ctrl
module tb_lane_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, frame_tick, run;
    logic [3:0] target_speed;
    logic [9:0] l1s, l1e, l2s, l2e, l3s, l3e, l4s, l4e, l5s, l5e, l6s, l6e;
    logic [9:0] c1s, c1e, c2s, c2e;
    logic [3:0] cur_speed;
    logic       busy, update_done;

    always #5 clk = ~clk;

    lane_scroll_ctrl #(.RAMP_FRAMES(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .run           (run),
        .target_speed  (target_speed),
        .line1_r_start (l1s), .line1_r_end (l1e),
        .line2_r_start (l2s), .line2_r_end (l2e),
        .line3_r_start (l3s), .line3_r_end (l3e),
        .line4_r_start (l4s), .line4_r_end (l4e),
        .line5_r_start (l5s), .line5_r_end (l5e),
        .line6_r_start (l6s), .line6_r_end (l6e),
        .line_c1_start (c1s), .line_c1_end (c1e),
        .line_c2_start (c2s), .line_c2_end (c2e),
        .cur_speed     (cur_speed),
        .busy          (busy),
        .update_done   (update_done)
    );

    logic [9:0] act_s [0:5];
    logic [9:0] act_e [0:5];
    assign act_s[0] = l1s; assign act_e[0] = l1e;
    assign act_s[1] = l2s; assign act_e[1] = l2e;
    assign act_s[2] = l3s; assign act_e[2] = l3e;
    assign act_s[3] = l4s; assign act_e[3] = l4e;
    assign act_s[4] = l5s; assign act_e[4] = l5e;
    assign act_s[5] = l6s; assign act_e[5] = l6e;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int offset;
        int speed;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    int rs_s [0:5] = '{1023, 0, 104, 208, 312, 416};
    int rs_e [0:5] = '{0, 63, 167, 271, 375, 479};

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Dash n (1..6) top row is offset + (n-2)*104, 64 rows tall, screen rows 0..479
    function automatic int exp_start(int o, int n);
        int top, bot;
        top = o + (n - 2) * 104;
        bot = top + 63;
        if (bot < 0 || top > 479) return 1023;
        return (top < 0) ? 0 : top;
    endfunction

    function automatic int exp_end(int o, int n);
        int top, bot;
        top = o + (n - 2) * 104;
        bot = top + 63;
        if (bot < 0 || top > 479) return 0;
        return (bot > 479) ? 479 : bot;
    endfunction

    task automatic check_reset_pattern(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_line%0d_start", tag, i + 1), act_s[i], rs_s[i]);
            check($sformatf("%s_line%0d_end", tag, i + 1), act_e[i], rs_e[i]);
        end
    endtask

    // Monitor: every commit pulse is matched against the oldest expected frame
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update_done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got update_done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("commit_cycle_off%0d", e.offset), cyc, e.cyc);
                    check($sformatf("cur_speed_off%0d", e.offset), cur_speed, e.speed);
                    for (int n = 1; n <= 6; n++) begin
                        check($sformatf("off%0d_line%0d_start", e.offset, n), act_s[n-1], exp_start(e.offset, n));
                        check($sformatf("off%0d_line%0d_end", e.offset, n), act_e[n-1], exp_end(e.offset, n));
                    end
                end
            end
        end
    end

    // Called just after a rising edge; t is the edge at which the tick is sampled
    task automatic tick(output int t);
        frame_tick = 1'b1;
        t = cyc + 1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic push_exp(input int off, input int spd, input int c);
        exp_t e;
        e.offset = off;
        e.speed  = spd;
        e.cyc    = c;
        sbq.push_back(e);
    endtask

    task automatic tick_exp(input int off, input int spd);
        int t;
        tick(t);
        push_exp(off, spd, t + 8);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, tx;
        reset_n      = 1'b0;
        frame_tick   = 1'b0;
        run          = 1'b1;
        target_speed = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_pattern("reset");
        check("reset_busy", busy, 0);
        check("reset_update_done", update_done, 0);
        check("reset_cur_speed", cur_speed, 0);
        check("c1_start", c1s, 212);
        check("c1_end", c1e, 215);
        check("c2_start", c2s, 424);
        check("c2_end", c2e, 427);
        @(posedge clk);
        #1;

        // Ramp up: offset uses the speed from before the step
        tick_exp(0, 1);
        tick_exp(1, 2);
        tick_exp(3, 3);
        tick_exp(6, 4);
        tick_exp(10, 4);
        check("ramp_line2_start", l2s, 10);
        check("ramp_line2_end", l2e, 73);
        check("ramp_line1_start", l1s, 1023);
        check("ramp_line1_end", l1e, 0);
        check("ramp_speed", cur_speed, 4);

        for (int k = 1; k <= 10; k++) tick_exp(10 + 4 * k, 4);
        check("off50_line1_start", l1s, 0);
        check("off50_line1_end", l1e, 9);
        check("off50_line6_start", l6s, 466);
        check("off50_line6_end", l6e, 479);
        check("off50_line2_start", l2s, 50);
        check("off50_line2_end", l2e, 113);

        // Nudge the offset parity so it lands on 100
        target_speed = 4'd5; tick_exp(54, 5);
        target_speed = 4'd4; tick_exp(59, 4);
        target_speed = 4'd5; tick_exp(63, 5);
        target_speed = 4'd4; tick_exp(68, 4);
        for (int k = 1; k <= 8; k++) tick_exp(68 + 4 * k, 4);

        // 100 + 4 wraps to 0
        tick_exp(0, 4);
        check_reset_pattern("wrap");

        // Second tick during the update is deferred to one more frame
        tick(t);
        push_exp(4, 4, t + 8);
        repeat (2) @(posedge clk);
        #1;
        tick(t2);
        push_exp(8, 4, t + 16);
        @(negedge clk);
        check("busy_during_update", busy, 1);
        repeat (30) @(posedge clk);
        #1;

        // Three ticks while busy collapse to one pending frame
        tick(t);
        push_exp(12, 4, t + 8);
        push_exp(16, 4, t + 16);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            tick(tx);
        end
        repeat (30) @(posedge clk);
        #1;
        check("idle_after_pending", busy, 0);

        // Reset in the middle of CALC aborts the update without a commit
        tick(t);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_pattern("abort");
        check("abort_busy", busy, 0);
        check("abort_update_done", update_done, 0);
        check("abort_cur_speed", cur_speed, 0);
        repeat (20) @(posedge clk);
        #1;

        // Ramp up again, then run=0 ramps down while scrolling continues
        tick_exp(0, 1);
        tick_exp(1, 2);
        tick_exp(3, 3);
        tick_exp(6, 4);
        run = 1'b0;
        tick_exp(10, 3);
        tick_exp(13, 2);
        tick_exp(15, 1);
        tick_exp(16, 0);

        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
